// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, types and helpers for the SHA-256 stream block
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Register word indices (byte offset >> 2)
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_INIT = 1;
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_ADD   = 2'd2
    } core_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - block buffer plus 64-round SHA-256 compression, one round per clock
module sha256_core
    import sha256_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [3:0]       wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             start,
    input  logic             use_iv,
    input  logic             last,
    output logic [7:0][31:0] h_out,
    output logic             busy,
    output logic             done
);

    core_state_t      state_q, state_d;
    logic [5:0]       round_q;
    logic             last_q;
    // The block buffer doubles as the sliding schedule window during rounds
    logic [15:0][31:0] w_q;
    // Working variables a..h live in v_q[0..7]
    logic [7:0][31:0] v_q;
    logic [7:0][31:0] h_q;
    logic [31:0]      t1, t2, w_new;

    assign h_out = h_q;
    assign busy  = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and done pulse (done coincides with the H update of a final block)
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ROUND;
            ST_ROUND: if (round_q == 6'd63) state_d = ST_ADD;
            ST_ADD: begin
                state_d = ST_IDLE;
                done    = last_q;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Round function and next schedule word
    always_comb begin
        t1    = v_q[7] + big_sigma1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
              + K[round_q] + w_q[0];
        t2    = big_sigma0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    end

    // Buffer fill, round datapath and final accumulate; the buffer is cleared after
    // each block so a short (tlast) block is implicitly zero-filled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_q     <= '0;
            v_q     <= '0;
            h_q     <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_en) w_q[wr_idx] <= wr_data;
                    if (start) begin
                        round_q <= '0;
                        last_q  <= last;
                        if (use_iv) begin
                            for (int i = 0; i < 8; i++) begin
                                v_q[i] <= IV[i];
                                h_q[i] <= IV[i];
                            end
                        end else begin
                            v_q <= h_q;
                        end
                    end
                end
                ST_ROUND: begin
                    round_q    <= round_q + 6'd1;
                    w_q[14:0]  <= w_q[15:1];
                    w_q[15]    <= w_new;
                    v_q[0]     <= t1 + t2;
                    v_q[1]     <= v_q[0];
                    v_q[2]     <= v_q[1];
                    v_q[3]     <= v_q[2];
                    v_q[4]     <= v_q[3] + t1;
                    v_q[5]     <= v_q[4];
                    v_q[6]     <= v_q[5];
                    v_q[7]     <= v_q[6];
                end
                ST_ADD: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    w_q     <= '0;
                    round_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sha256_stream_v1_0.sv
// rtl/sha256_stream_v1_0.sv - AXI-Lite register file and AXI-Stream intake around sha256_core
module sha256_stream_v1_0
    import sha256_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 6,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid
);

    logic [1:0]       ctrl_q;
    logic             done_q;
    logic [3:0]       wcnt_q;
    logic             core_busy, core_done;
    logic [7:0][31:0] h_state;
    logic             wr_fire, ctrl_wr, init_wr, accept, start;
    logic [3:0]       wr_idx, rd_idx;
    logic [31:0]      rd_word;
    logic             unused_ok;

    assign wr_idx  = s00_axi_awaddr[5:2];
    assign rd_idx  = s00_axi_araddr[5:2];
    assign wr_fire = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
    assign ctrl_wr = wr_fire && (wr_idx == REG_CTRL) && s00_axi_wstrb[0];
    assign init_wr = ctrl_wr && s00_axi_wdata[CTRL_INIT];

    assign s00_axis_tready = ctrl_q[CTRL_EN] && !core_busy;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign start           = accept && (s00_axis_tlast || (wcnt_q == 4'd15));

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    assign unused_ok = ^{s00_axis_aclk, s00_axis_aresetn, s00_axi_awprot, s00_axi_arprot,
                         s00_axis_tstrb, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[31:2], s00_axi_wstrb[3:1]};

    sha256_core u_core (
        .aclk    (s00_axi_aclk),
        .aresetn (s00_axi_aresetn),
        .wr_en   (accept),
        .wr_idx  (wcnt_q),
        .wr_data (bswap32(s00_axis_tdata)),
        .start   (start),
        .use_iv  (ctrl_q[CTRL_INIT]),
        .last    (s00_axis_tlast),
        .h_out   (h_state),
        .busy    (core_busy),
        .done    (core_done)
    );

    // Write channel: one-cycle aw/w ready pulse, then hold bvalid until bready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
                s00_axi_awready <= 1'b1;
                s00_axi_wready  <= 1'b1;
            end else begin
                s00_axi_awready <= 1'b0;
                s00_axi_wready  <= 1'b0;
            end
            if (wr_fire) begin
                s00_axi_bvalid <= 1'b1;
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // CTRL: INIT self-clears when a block starts; a host write in the same cycle wins
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_q <= 2'b00;
        end else begin
            if (start) ctrl_q[CTRL_INIT] <= 1'b0;
            if (ctrl_wr) ctrl_q <= s00_axi_wdata[1:0];
        end
    end

    // DONE: set at the end of a tlast block, cleared by INIT or the next accepted word
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            done_q <= 1'b0;
        end else if (init_wr || accept) begin
            done_q <= 1'b0;
        end else if (core_done) begin
            done_q <= 1'b1;
        end
    end

    // Word position within the current block
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wcnt_q <= 4'd0;
        end else if (start) begin
            wcnt_q <= 4'd0;
        end else if (accept) begin
            wcnt_q <= wcnt_q + 4'd1;
        end
    end

    // Read data mux; upper half of the map is the byte-swapped digest
    always_comb begin
        rd_word = '0;
        if (rd_idx[3]) begin
            rd_word = bswap32(h_state[rd_idx[2:0]]);
        end else if (rd_idx == REG_CTRL) begin
            rd_word = {30'd0, ctrl_q};
        end else if (rd_idx == REG_STATUS) begin
            rd_word = {30'd0, done_q, core_busy};
        end
    end

    // Read channel: one-cycle arready pulse, then hold rvalid/rdata until rready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_arready && !s00_axi_rvalid;
            if (s00_axi_arready && s00_axi_arvalid) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_word;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_stream_v1_0.sv
// tb/tb_sha256_stream_v1_0.sv - scoreboard bench for sha256_stream_v1_0
module tb_sha256_stream_v1_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hf;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        tready;
    logic [31:0] tdata = '0;
    logic        tlast = 1'b0, tvalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0]  msg [0:31];
    logic [255:0] exp_q [$];

    localparam logic [255:0] DIG_REQ21 = 256'h049da052634feb56ce6ec0bc648c672011edff1cb272b53113bbc90a8f00249c;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    always #5 clk = ~clk;

    sha256_stream_v1_0 dut (
        .s00_axi_aclk     (clk),
        .s00_axi_aresetn  (rst_n),
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axi_awaddr   (awaddr),
        .s00_axi_awprot   (3'b000),
        .s00_axi_awvalid  (awvalid),
        .s00_axi_awready  (awready),
        .s00_axi_wdata    (wdata),
        .s00_axi_wstrb    (wstrb),
        .s00_axi_wvalid   (wvalid),
        .s00_axi_wready   (wready),
        .s00_axi_bresp    (bresp),
        .s00_axi_bvalid   (bvalid),
        .s00_axi_bready   (bready),
        .s00_axi_araddr   (araddr),
        .s00_axi_arprot   (3'b000),
        .s00_axi_arvalid  (arvalid),
        .s00_axi_arready  (arready),
        .s00_axi_rdata    (rdata),
        .s00_axi_rresp    (rresp),
        .s00_axi_rvalid   (rvalid),
        .s00_axi_rready   (rready),
        .s00_axis_tready  (tready),
        .s00_axis_tdata   (tdata),
        .s00_axis_tstrb   (4'hf),
        .s00_axis_tlast   (tlast),
        .s00_axis_tvalid  (tvalid)
    );

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, output logic [1:0] resp);
        bit ok;
        resp = 2'bxx;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check_eq("aw_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; resp = bresp; break; end
        end
        @(posedge clk); #1;
        bready = 1'b0;
        if (!ok) check_eq("b_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        data = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!ok) check_eq("ar_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1'b1; data = rdata; resp = rresp; break; end
        end
        @(posedge clk); #1;
        rready = 1'b0;
        if (!ok) check_eq("r_timeout", 32'd0, 32'd1);
    endtask

    // Send msg[0..n-1], tlast on the final word; gaps drop tvalid between words
    task automatic send(input int n, input bit gaps, output int max_wait);
        int i, waited;
        bit hs;
        max_wait = 0; waited = 0; i = 0;
        @(posedge clk); #1;
        tdata = msg[0]; tlast = (n == 1); tvalid = 1'b1;
        while (i < n) begin
            @(negedge clk);
            hs = tready;
            @(posedge clk); #1;
            if (hs) begin
                if (waited > max_wait) max_wait = waited;
                waited = 0;
                i++;
                if (gaps && i < n) begin
                    tvalid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                if (i < n) begin
                    tdata = msg[i]; tlast = (i == n - 1); tvalid = 1'b1;
                end else begin
                    tvalid = 1'b0; tlast = 1'b0;
                end
            end else begin
                waited++;
                if (waited > 200) begin
                    check_eq("stream_timeout", 32'(i), 32'(n));
                    tvalid = 1'b0; tlast = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic compare_digest(input string tag);
        logic [255:0] e;
        logic [31:0]  d;
        logic [1:0]   r;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int n = 0; n < 8; n++) begin
            axi_read(6'(32 + 4 * n), d, r);
            check_eq($sformatf("%s_digest%0d", tag, n), d, swap(e[255 - 32 * n -: 32]));
        end
    endtask

    task automatic load_req21();
        logic [31:0] head [0:15];
        head = '{32'h64343962, 32'h39623732, 32'h64343339, 32'h38306533,
                 32'h65323561, 32'h37643235, 32'h64376164, 32'h61666261,
                 32'h34383463, 32'h33656665, 32'h33356137, 32'h65653038,
                 32'h38383039, 32'h63613766, 32'h66653265, 32'h39656463};
        for (int i = 0; i < 16; i++) msg[i] = head[i];
        msg[16] = 32'h00000080;
        for (int i = 17; i < 31; i++) msg[i] = 32'h0;
        msg[31] = 32'h00020000;
    endtask

    task automatic load_abc();
        msg[0] = 32'h80636261;
        for (int i = 1; i < 15; i++) msg[i] = 32'h0;
        msg[15] = 32'h18000000;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          mw, tr_hi;

        repeat (3) @(posedge clk);
        check_eq("rst_tready", 32'(tready), 32'd0);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        #1 rst_n = 1'b1;
        axi_read(6'h00, d, r); check_eq("rst_ctrl", d, 32'h0);
        axi_read(6'h04, d, r); check_eq("rst_status", d, 32'h0);
        axi_read(6'h20, d, r); check_eq("rst_digest0", d, 32'h0);

        // Disabled: tready must stay low with tvalid held
        axi_write(6'h00, 32'h0, r);
        tr_hi = 0;
        tvalid = 1'b1; tdata = 32'h12345678;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tready) tr_hi++;
        end
        @(posedge clk); #1 tvalid = 1'b0;
        check_eq("dis_tready_cycles", 32'(tr_hi), 32'd0);
        axi_read(6'h04, d, r); check_eq("dis_status", d, 32'h0);

        // Reserved read and RO write
        axi_read(6'h08, d, r);
        check_eq("rsvd_rdata", d, 32'h0);
        check_eq("rsvd_rresp", 32'(r), 32'd0);
        axi_write(6'h04, 32'hffffffff, r);
        check_eq("ro_bresp", 32'(r), 32'd0);
        axi_read(6'h04, d, r); check_eq("ro_status", d, 32'h0);

        // "abc"
        axi_write(6'h00, 32'h3, r);
        load_abc();
        exp_q.push_back(DIG_ABC);
        send(16, 1'b0, mw);
        repeat (70) @(posedge clk);
        axi_read(6'h04, d, r); check_eq("abc_status", d, 32'h2);
        axi_read(6'h00, d, r); check_eq("abc_ctrl_init_clr", d, 32'h1);
        compare_digest("abc");

        // INIT write clears DONE; single tlast word exercises zero fill (empty message)
        axi_write(6'h00, 32'h3, r);
        axi_read(6'h04, d, r); check_eq("init_clr_done", d, 32'h0);
        msg[0] = 32'h00000080;
        exp_q.push_back(DIG_EMPTY);
        send(1, 1'b0, mw);
        repeat (70) @(posedge clk);
        axi_read(6'h04, d, r); check_eq("empty_status", d, 32'h2);
        compare_digest("empty");

        // Two-block message, gapped stream
        axi_write(6'h00, 32'h3, r);
        load_req21();
        exp_q.push_back(DIG_REQ21);
        send(32, 1'b1, mw);
        repeat (70) @(posedge clk);
        axi_read(6'h04, d, r); check_eq("two_status", d, 32'h2);
        compare_digest("two");

        // Same message, tvalid held continuously across both blocks
        axi_write(6'h00, 32'h3, r);
        exp_q.push_back(DIG_REQ21);
        send(32, 1'b0, mw);
        check_eq("cont_stall_in_range", 32'(mw >= 64 && mw <= 66), 32'd1);
        repeat (70) @(posedge clk);
        axi_read(6'h04, d, r); check_eq("cont_status", d, 32'h2);
        compare_digest("cont");

        // Reset around round 30 of a block
        axi_write(6'h00, 32'h3, r);
        load_abc();
        send(16, 1'b0, mw);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_tready_async", 32'(tready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_tready", 32'(tready), 32'd0);
        axi_read(6'h04, d, r); check_eq("midrst_status", d, 32'h0);
        for (int n = 0; n < 8; n++) begin
            axi_read(6'(32 + 4 * n), d, r);
            check_eq($sformatf("midrst_digest%0d", n), d, 32'h0);
        end

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
